// File: rtl/host_if_responder.sv
`default_nettype none
// ============================================================================
// Module  : host_if_responder
// Brief   : Host config/readback bus responder with a local register file,
//           a memory window, a start pulse and a sticky done flag.
// Revision: 1.0 - initial release
// ============================================================================
module host_if_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int REG_IDX_W  = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               write_en,
    output logic                               write_rdy,
    input  logic [ADDR_WIDTH-1:0]              write_addr,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic                               read_en,
    output logic                               read_rdy,
    input  logic [ADDR_WIDTH-1:0]              read_addr,
    input  logic                               read_data_rdy,
    output logic                               read_data_vld,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-2:0]              mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic                               mem_rdy,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    input  logic                               mem_rvld,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] cfg_regs,
    output logic                               start,
    input  logic                               busy_in,
    input  logic                               done_in
);
    localparam logic [REG_IDX_W-1:0] c_CTRL_IDX = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Entry 0 is the CTRL slot; it is never written and only kept for uniform indexing.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_done;
    logic                  r_start;
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-2:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_mem;
    logic                  w_rd_mem;
    logic [REG_IDX_W-1:0]  w_wr_idx;
    logic [REG_IDX_W-1:0]  w_rd_idx;
    logic                  w_ctrl_wr;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign write_rdy = (r_state == IDLE) & ~rst;
    assign read_rdy  = (r_state == IDLE) & ~rst & ~write_en;

    assign w_wr_acc  = write_en & write_rdy;
    assign w_rd_acc  = read_en & read_rdy;
    assign w_wr_mem  = write_addr[ADDR_WIDTH-1];
    assign w_rd_mem  = read_addr[ADDR_WIDTH-1];
    assign w_wr_idx  = write_addr[REG_IDX_W-1:0];
    assign w_rd_idx  = read_addr[REG_IDX_W-1:0];
    assign w_ctrl_wr = w_wr_acc & ~w_wr_mem & (w_wr_idx == c_CTRL_IDX);
    assign w_rd_word = (w_rd_idx == c_CTRL_IDX) ?
                       {{(DATA_WIDTH-2){1'b0}}, r_done, busy_in} : r_regs[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_acc) begin
                    if (w_wr_mem) w_state_nxt = MEM_REQ;
                end else if (w_rd_acc) begin
                    w_state_nxt = w_rd_mem ? MEM_REQ : RESP;
                end
            end
            MEM_REQ:  if (mem_rdy)       w_state_nxt = r_mem_we ? IDLE : MEM_WAIT;
            MEM_WAIT: if (mem_rvld)      w_state_nxt = RESP;
            RESP:     if (read_data_rdy) w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_done      <= 1'b0;
            r_start     <= 1'b0;
            r_vld       <= 1'b0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_start <= w_ctrl_wr & write_data[0];

            // A done pulse outranks a simultaneous clear request.
            if (done_in) begin
                r_done <= 1'b1;
            end else if (w_ctrl_wr & write_data[1]) begin
                r_done <= 1'b0;
            end

            if (w_wr_acc & ~w_wr_mem & (w_wr_idx != c_CTRL_IDX)) begin
                r_regs[w_wr_idx] <= write_data;
            end

            if (w_wr_acc & w_wr_mem) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= write_addr[ADDR_WIDTH-2:0];
                r_mem_wdata <= write_data;
            end else if (w_rd_acc & w_rd_mem) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= read_addr[ADDR_WIDTH-2:0];
            end else if (r_mem_en & mem_rdy) begin
                r_mem_en <= 1'b0;
            end

            // Read data stays frozen while the host stalls the response.
            if (w_rd_acc & ~w_rd_mem) begin
                r_rdata <= w_rd_word;
                r_vld   <= 1'b1;
            end else if ((r_state == MEM_WAIT) & mem_rvld) begin
                r_rdata <= mem_rdata;
                r_vld   <= 1'b1;
            end else if (r_vld & read_data_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cfg
            assign cfg_regs[gi*DATA_WIDTH-1 -: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign start         = r_start;
    assign read_data_vld = r_vld;
    assign read_data     = r_rdata;
    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/host_if_responder.md
Name: host_if_responder

Overview:
- Accelerator-side responder for the host configuration/readback bus. It terminates write_en/write_rdy and read_en/read_rdy/read_data_vld/read_data_rdy transactions.
- Decodes each address into either a local configuration register file or a downstream memory window, and exports the configuration registers to the datapath.
- Also produces the accelerator start pulse and keeps a sticky done flag.

Parameters:
ADDR_WIDTH, 16, host address width; MSB selects the memory window.
DATA_WIDTH, 32, host data width.
NUM_REGS, 8, local register count including CTRL at index 0; power of 2, at least 2.
REG_IDX_W, 3, log2(NUM_REGS); index is addr[REG_IDX_W-1:0].

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
write_en  in  1  host write request
write_rdy  out  1  responder can accept a write
write_addr  in  ADDR_WIDTH  write address
write_data  in  DATA_WIDTH  write data
read_en  in  1  host read request
read_rdy  out  1  responder can accept a read
read_addr  in  ADDR_WIDTH  read address
read_data_rdy  in  1  host ready to take read data
read_data_vld  out  1  read data valid
read_data  out  DATA_WIDTH  read data
mem_en  out  1  memory-window request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH-1  memory word address (host addr without MSB)
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdy  in  1  memory accepts request this cycle
mem_rdata  in  DATA_WIDTH  memory read data
mem_rvld  in  1  mem_rdata valid, single-cycle pulse
cfg_regs  out  (NUM_REGS-1)*DATA_WIDTH  regs 1..NUM_REGS-1; reg i at bits [i*DW-1:(i-1)*DW]
start  out  1  accelerator start pulse
busy_in  in  1  accelerator busy status
done_in  in  1  accelerator done pulse

Behaviour:
- One clock domain; reset is synchronous and active-high on rst.
- Reset values: state IDLE, every output 0, all registers 0, done flag 0.
- write_rdy and read_rdy are forced 0 while rst is high.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- write_rdy = (state==IDLE) & ~rst.
- read_rdy = (state==IDLE) & ~rst & ~write_en. A simultaneous write wins; the read is not accepted and the host retries.
- Accept = en & rdy at a rising edge.
- Local write (addr MSB=0):
  - Index 1..NUM_REGS-1: register and cfg_regs update at the accepting edge.
  - Index 0 (CTRL): bit0=1 gives start=1 for exactly the next cycle. bit1=1 clears the done flag. CTRL bits are not stored.
  - Address bits between REG_IDX_W and MSB-1 are ignored (aliasing).
  - State stays IDLE, so back-to-back writes run at 1 per cycle.
- Local read (MSB=0):
  - read_data is registered at the accept edge and the FSM goes to RESP; read_data_vld=1 the following cycle.
  - CTRL read returns {0..., done_flag, busy_in}, with busy_in sampled at accept.
- Memory access (MSB=1):
  - Accept goes to MEM_REQ, with mem_en=1, mem_we, mem_addr and mem_wdata registered and held until mem_rdy.
  - Write: on mem_en&mem_rdy go to IDLE; write_rdy returns the next cycle.
  - Read: on mem_en&mem_rdy go to MEM_WAIT with mem_en=0. On mem_rvld, capture mem_rdata and go to RESP.
  - A mem_rvld pulse outside MEM_WAIT is ignored.
- RESP: read_data_vld=1 with read_data held stable until read_data_vld & read_data_rdy, then go to IDLE with vld=0 the next cycle.
- Done flag:
  - Set by a done_in pulse, cleared by a CTRL bit1 write.
  - Simultaneous set and clear: set wins.
- Starting a write while start is high is legal. Each CTRL bit0 write yields its own 1-cycle pulse.
- Reset mid-operation (any state): return to IDLE next edge. Any pending mem request and read response are dropped; vld/mem_en go to 0 and registers are cleared.

Test Plan:
- Reset 2 cycles: all outputs 0 during reset; write_rdy=read_rdy=1 on the first cycle after release.
- Back-to-back writes 0x0001=0xDEADBEEF, 0x0007=0x12345678: cfg_regs[31:0]=0xDEADBEEF and cfg_regs[223:192]=0x12345678; write_rdy never drops.
- Write 0x0000=0x1: start high exactly 1 cycle. Pulse done_in, then read 0x0000 with busy_in=0: read_data=0x2. Write 0x0000=0x2, then read: 0x0.
- Read 0x0001 with read_data_rdy held 0 for 5 cycles: read_data_vld=1 and read_data=0xDEADBEEF stable throughout; read_rdy=0; completes on rdy=1, and read_rdy=1 the next cycle.
- Memory read 0x8010 with mem_rdy delayed 3 cycles and mem_rvld 2 cycles later carrying 0xCAFEF00D: mem_addr=0x0010, mem_we=0, read_data=0xCAFEF00D. Memory write 0x8004=0x55: mem_we=1, mem_wdata=0x55.
- Edge cases:
  - write_en and read_en asserted in the same cycle: the write is taken and read_rdy=0 that cycle.
  - rst asserted while in MEM_WAIT: returns to IDLE and a late mem_rvld is ignored.
  - done_in coincident with a clear write: the done flag reads 1.
